// File: rtl/aes128_cmd_frontend.sv
// Request/response command frontend sequencing a single AES-128 core operation.
// Optional WAIT watchdog enabled by defining AES128_FE_TIMEOUT_EN.
module aes128_cmd_frontend #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_dec_i,
    input  logic [127:0]     req_key_i,
    input  logic [127:0]     req_text_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [127:0]     rsp_text_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             core_start_enc_o,
    output logic             core_start_dec_o,
    output logic [127:0]     core_key_o,
    output logic [127:0]     core_text_o,
    input  logic             core_ready_i,
    input  logic             core_done_i,
    input  logic [127:0]     core_text_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q;
    logic               ready_q;
    logic               dec_q;
    logic [127:0]       key_q;
    logic [127:0]       text_q;
    logic [TAG_W-1:0]   tag_q;
    logic [127:0]       rsp_text_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [15:0]        done_cnt;
    logic               rsp_ok;

`ifdef AES128_FE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        rsp_err_q;
    logic [15:0] to_q;
    assign rsp_ok    = ~rsp_err_q;
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_ok    = 1'b1;
    assign rsp_err_o = 1'b0;
`endif

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_text_o  = rsp_text_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign core_key_o  = key_q;
    assign core_text_o = text_q;

    // Start is qualified by the core's registered ready so it fires in the same
    // cycle the core becomes idle; it is high only in the ISSUE-exit cycle.
    assign core_start_enc_o = (state_q == ISSUE) && core_ready_i && !dec_q;
    assign core_start_dec_o = (state_q == ISSUE) && core_ready_i && dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            dec_q      <= 1'b0;
            key_q      <= '0;
            text_q     <= '0;
            tag_q      <= '0;
            rsp_text_q <= '0;
            rsp_tag_q  <= '0;
            done_cnt   <= '0;
`ifdef AES128_FE_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
            to_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid_i && ready_q) begin
                        dec_q   <= req_dec_i;
                        key_q   <= req_key_i;
                        text_q  <= req_text_i;
                        tag_q   <= req_tag_i;
                        ready_q <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_ready_i) begin
                        state_q <= WAIT;
`ifdef AES128_FE_TIMEOUT_EN
                        to_q    <= '0;
`endif
                    end
                end
                WAIT: begin
                    // A done arriving on the expiry cycle takes priority.
                    if (core_done_i) begin
                        rsp_text_q <= core_text_i;
                        rsp_tag_q  <= tag_q;
`ifdef AES128_FE_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
`endif
                        state_q    <= RESP;
                    end
`ifdef AES128_FE_TIMEOUT_EN
                    else if (to_q == TO_LAST) begin
                        rsp_text_q <= '0;
                        rsp_tag_q  <= tag_q;
                        rsp_err_q  <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        if (rsp_ok && (done_cnt != 16'hFFFF)) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
